// File: rtl/mcu_block_reader_if.sv
// AXI4-Stream bundle shared by the line inputs and the block output of mcu_block_reader.
interface axi4_stream_if #(
  parameter int TDATA_WIDTH = 8
);
  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tstrb;
  logic [TDATA_WIDTH/8-1:0] tkeep;
  logic                     tvalid;
  logic                     tready;
  logic                     tlast;
  logic                     tuser;
  logic                     tdest;
  logic                     tid;

  modport master (
    output tdata, tstrb, tkeep, tvalid, tlast, tuser, tdest, tid,
    input  tready
  );

  modport slave (
    input  tdata, tstrb, tkeep, tvalid, tlast, tuser, tdest, tid,
    output tready
  );
endinterface

// File: rtl/mcu_block_reader.sv
// Reorders 8 parallel line streams into a stream of 8x8 pixel blocks (row-major inside each block).
// Optional framing checker enabled by defining MCU_BLOCK_READER_CHECK_EN.
module mcu_block_reader #(
  parameter int BUF_AMOUNT  = 8,
  parameter int PX_WIDTH    = 8,
  parameter int FRAME_RES_X = 1280
) (
  input  logic          clk_i,
  input  logic          rst_i,
  axi4_stream_if.slave  video_i [BUF_AMOUNT-1:0],
  axi4_stream_if.master block_o,
  output logic          err_o
);
  localparam int TDATA_WIDTH = ((PX_WIDTH + 7) / 8) * 8;
  localparam int KEEP_WIDTH  = TDATA_WIDTH / 8;
  localparam int BLK_NUM     = FRAME_RES_X / 8;
  localparam int BLK_W       = (BLK_NUM > 1) ? $clog2(BLK_NUM) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLK_NUM - 1);

  logic [2:0]       px_cnt;
  logic [2:0]       row_cnt;
  logic [BLK_W-1:0] blk_cnt;

  logic                   out_valid;
  logic [TDATA_WIDTH-1:0] out_data;
  logic [KEEP_WIDTH-1:0]  out_keep;
  logic                   out_last;
  logic                   out_user;

  logic [BUF_AMOUNT-1:0]  in_valid;
  logic [BUF_AMOUNT-1:0]  in_last;
  logic [BUF_AMOUNT-1:0]  in_user;
  logic [TDATA_WIDTH-1:0] in_data [BUF_AMOUNT];

  logic                   sel_valid;
  logic                   sel_last;
  logic                   sel_user;
  logic [TDATA_WIDTH-1:0] sel_data;
  logic                   take;
  logic                   consume;

  // Only the stream selected by row_cnt ever sees tready; the rest are held off.
  for (genvar k = 0; k < BUF_AMOUNT; k++) begin : g_in
    assign in_valid[k]       = video_i[k].tvalid;
    assign in_last[k]        = video_i[k].tlast;
    assign in_user[k]        = video_i[k].tuser;
    assign in_data[k]        = video_i[k].tdata;
    assign video_i[k].tready = take && (row_cnt == 3'(k));
  end

  assign take    = !rst_i && (!out_valid || block_o.tready);
  assign consume = take && sel_valid;

  always_comb begin
    sel_valid = in_valid[row_cnt];
    sel_last  = in_last[row_cnt];
    sel_user  = in_user[row_cnt];
    sel_data  = in_data[row_cnt];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      px_cnt  <= '0;
      row_cnt <= '0;
      blk_cnt <= '0;
    end else if (consume) begin
      px_cnt <= px_cnt + 3'd1;
      if (px_cnt == 3'd7) begin
        row_cnt <= row_cnt + 3'd1;
        if (row_cnt == 3'd7) begin
          blk_cnt <= (blk_cnt == BLK_LAST) ? '0 : blk_cnt + BLK_W'(1);
        end
      end
    end
  end

  // Single skid-free output stage: a new beat is only taken when the slot is empty or draining.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_user  <= 1'b0;
    end else if (consume) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_keep  <= '1;
      out_last  <= (px_cnt == 3'd7) && (row_cnt == 3'd7);
      out_user  <= sel_user;
    end else if (block_o.tready) begin
      out_valid <= 1'b0;
    end
  end

  assign block_o.tvalid = out_valid;
  assign block_o.tdata  = out_data;
  assign block_o.tstrb  = out_keep;
  assign block_o.tkeep  = out_keep;
  assign block_o.tlast  = out_last;
  assign block_o.tuser  = out_user;
  assign block_o.tid    = 1'b0;
  assign block_o.tdest  = 1'b0;

`ifdef MCU_BLOCK_READER_CHECK_EN
  logic err_q;
  logic frame_bad;

  // Input tlast must mark line ends; tuser may only appear on the first pixel of the frame.
  assign frame_bad = (sel_last != ((px_cnt == 3'd7) && (blk_cnt == BLK_LAST))) ||
                     (sel_user && !((row_cnt == 3'd0) && (px_cnt == 3'd0) && (blk_cnt == '0)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (consume && frame_bad) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_mcu_block_reader.sv
// Scoreboard bench for mcu_block_reader: line sources, random backpressure/stalls, reset and framing-error cases.
module tb_mcu_block_reader;
  localparam int RES_X = 16;
`ifdef MCU_BLOCK_READER_CHECK_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;
  always #5 clk = ~clk;

  axi4_stream_if #(.TDATA_WIDTH(8)) video_if [7:0] ();
  axi4_stream_if #(.TDATA_WIDTH(8)) block_if ();

  mcu_block_reader #(
    .BUF_AMOUNT (8),
    .PX_WIDTH   (8),
    .FRAME_RES_X(RES_X)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .video_i(video_if),
    .block_o(block_if),
    .err_o  (err)
  );

  logic [7:0] stall     = 8'd0;
  logic       inj       = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] fire;
  logic [7:0] ready_vec;
  logic [3:0] col_a [8];

  // Each source emits one image line: pixel value row*16+col, tlast at end of line, tuser at frame start.
  for (genvar k = 0; k < 8; k++) begin : g_src
    logic [3:0] col;
    always @(posedge clk) begin
      if (rst) col <= 4'd0;
      else if (video_if[k].tvalid && video_if[k].tready) col <= col + 4'd1;
    end
    assign video_if[k].tvalid = !stall[k];
    assign video_if[k].tdata  = 8'(k * 16) + {4'd0, col};
    assign video_if[k].tlast  = (col == 4'd15) || ((k == 2) && inj && (col == 4'd5));
    assign video_if[k].tuser  = (k == 0) && (col == 4'd0);
    assign video_if[k].tstrb  = 1'b1;
    assign video_if[k].tkeep  = 1'b1;
    assign video_if[k].tid    = 1'b0;
    assign video_if[k].tdest  = 1'b0;
    assign fire[k]      = video_if[k].tvalid && video_if[k].tready;
    assign ready_vec[k] = video_if[k].tready;
    assign col_a[k]     = col;
  end

  assign block_if.tready = out_ready;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  beat_t sb [$];
  int checks      = 0;
  int fails       = 0;
  int total_beats = 0;

  task automatic check_output(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: a 16-pixel-wide, 8-line frame read as two 8x8 blocks in row-major order.
  task automatic push_frame();
    beat_t b;
    for (int blk = 0; blk < RES_X / 8; blk++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          b.data = 8'(r * 16 + blk * 8 + c);
          b.last = (r == 7) && (c == 7);
          b.user = (r == 0) && (blk == 0) && (c == 0);
          sb.push_back(b);
        end
  endtask

  logic       prev_stall = 1'b0;
  logic [9:0] held       = '0;

  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_output("stall_tvalid", block_if.tvalid, 1);
        check_output("stall_payload", {block_if.tdata, block_if.tlast, block_if.tuser}, held);
      end
      if (block_if.tvalid && block_if.tready) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_beat: got data %0d, expected no beat", block_if.tdata);
        end else begin
          e = sb.pop_front();
          check_output("beat_data", block_if.tdata, e.data);
          check_output("beat_last", block_if.tlast, e.last);
          check_output("beat_user", block_if.tuser, e.user);
          check_output("beat_side", {block_if.tkeep, block_if.tstrb, block_if.tid, block_if.tdest}, 4'b1100);
          total_beats++;
        end
      end
      prev_stall = block_if.tvalid && !block_if.tready;
      held       = {block_if.tdata, block_if.tlast, block_if.tuser};
    end
  end

  // mode 0: ready held high; 1: ready toggles each cycle; 2: random ready and random source stalls.
  task automatic apply_stimulus(input int mode, input int bound, output int cycles);
    cycles = 0;
    while (sb.size() != 0 && cycles < bound) begin
      @(posedge clk);
      #1;
      cycles++;
      case (mode)
        1: out_ready = ~out_ready;
        2: begin
          out_ready = ($urandom_range(3) != 0);
          for (int k = 0; k < 8; k++) stall[k] = ($urandom_range(3) == 0);
        end
        default: out_ready = 1'b1;
      endcase
    end
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL drain_timeout: got %0d beats left, expected 0", sb.size());
    end
    stall     = 8'd0;
    out_ready = 1'b1;
  endtask

  initial begin
    int cyc;
    int base;
    rst       = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_tvalid", block_if.tvalid, 0);
    check_output("reset_tdata", block_if.tdata, 0);
    check_output("reset_tlast", block_if.tlast, 0);
    check_output("reset_err", err, 0);
    check_output("reset_tready", ready_vec, 0);
    rst = 1'b0;
    #1;
    check_output("ready_row0_only", ready_vec, 1);

    $display("[TB] full-rate frame");
    push_frame();
    apply_stimulus(0, 400, cyc);
    check_output("throughput", (cyc <= 130) ? 1 : 0, 1);

    $display("[TB] toggling backpressure frame");
    push_frame();
    apply_stimulus(1, 1000, cyc);

    $display("[TB] random backpressure and stall frames");
    for (int n = 0; n < 3; n++) begin
      push_frame();
      apply_stimulus(2, 3000, cyc);
    end
    check_output("err_clean", err, 0);

    $display("[TB] stream 3 stall");
    base     = total_beats;
    stall[3] = 1'b1;
    push_frame();
    repeat (44) @(posedge clk);
    #1;
    check_output("beats_before_stall", total_beats - base, 24);
    check_output("paused_tvalid", block_if.tvalid, 0);
    check_output("stream4_untouched", col_a[4], 0);
    check_output("stream3_untouched", col_a[3], 0);
    stall = 8'd0;
    apply_stimulus(0, 400, cyc);

    $display("[TB] reset mid-block");
    base = total_beats;
    push_frame();
    cyc = 0;
    while ((total_beats - base) < 41 && cyc < 300) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    check_output("reached_beat40", (total_beats - base >= 41) ? 1 : 0, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("rst_tvalid", block_if.tvalid, 0);
    check_output("rst_tdata", block_if.tdata, 0);
    check_output("rst_tready", ready_vec, 0);
    sb.delete();
    rst = 1'b0;
    push_frame();
    apply_stimulus(0, 400, cyc);

    $display("[TB] framing error injection");
    push_frame();
    inj = 1'b1;
    cyc = 0;
    while (cyc < 300) begin
      @(negedge clk);
      #1;
      cyc++;
      if (fire[2] && col_a[2] == 4'd5) break;
    end
    check_output("inject_seen", (fire[2] && col_a[2] == 4'd5) ? 1 : 0, 1);
    check_output("err_before_inject", err, 0);
    @(posedge clk);
    #1;
    inj = 1'b0;
    check_output("err_after_inject", err, EXP_ERR);
    apply_stimulus(0, 400, cyc);
    check_output("err_held", err, EXP_ERR);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
